// File: rtl/max_pool2_if.sv
// Window-in / max-out bundle for the 2x2 max-pooling element.
// master drives the window, slave (the pooling element) returns the result.
interface max_pool2_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in00;
  logic [DATA_WIDTH-1:0] in01;
  logic [DATA_WIDTH-1:0] in10;
  logic [DATA_WIDTH-1:0] in11;
  logic [DATA_WIDTH-1:0] out;
  logic [1:0]            out_idx;
  logic                  out_valid;

  modport master (
    output in_valid, in00, in01, in10, in11,
    input  out, out_idx, out_valid
  );

  modport slave (
    input  in_valid, in00, in01, in10, in11,
    output out, out_idx, out_valid
  );
endinterface

// File: rtl/max_pool2.sv
// 2x2 max-pooling element: two-stage pipeline returning the window maximum and
// its {row, col} position, lowest position winning on ties.
module max_pool2 #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter bit          SIGNED     = 1'b0
) (
  input logic         clk,
  input logic         rst_n,
  max_pool2_if.slave  bus
);

  // Strict greater-than: the later candidate only wins when strictly larger.
  function automatic logic f_gt(input logic [DATA_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] b);
    if (SIGNED) return $signed(a) > $signed(b);
    return a > b;
  endfunction

  logic                  w_c0, w_c1, w_r2;
  logic [DATA_WIDTH-1:0] w_m0, w_m1, w_max;
  logic [1:0]            w_idx;

  logic                  r_v1;
  logic [DATA_WIDTH-1:0] r_m0, r_m1;
  logic                  r_c0, r_c1;
  logic                  r_v2;
  logic [DATA_WIDTH-1:0] r_out;
  logic [1:0]            r_idx;

  always_comb begin
    w_c0 = f_gt(bus.in01, bus.in00);
    w_m0 = w_c0 ? bus.in01 : bus.in00;
    w_c1 = f_gt(bus.in11, bus.in10);
    w_m1 = w_c1 ? bus.in11 : bus.in10;
  end

  always_comb begin
    w_r2  = f_gt(r_m1, r_m0);
    w_max = w_r2 ? r_m1 : r_m0;
    w_idx = w_r2 ? {1'b1, r_c1} : {1'b0, r_c0};
  end

  // Stage 1: per-row maxima; data only loads on valid so idle garbage never propagates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1 <= 1'b0;
      r_m0 <= '0;
      r_m1 <= '0;
      r_c0 <= 1'b0;
      r_c1 <= 1'b0;
    end else begin
      r_v1 <= bus.in_valid;
      if (bus.in_valid) begin
        r_m0 <= w_m0;
        r_m1 <= w_m1;
        r_c0 <= w_c0;
        r_c1 <= w_c1;
      end
    end
  end

  // Stage 2: row maxima merged; result holds across bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v2  <= 1'b0;
      r_out <= '0;
      r_idx <= 2'b00;
    end else begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_out <= w_max;
        r_idx <= w_idx;
      end
    end
  end

  assign bus.out       = r_out;
  assign bus.out_idx   = r_idx;
  assign bus.out_valid = r_v2;

endmodule

// File: tb/tb_max_pool2.sv
// Randomised and directed bench for max_pool2: unsigned and signed instances share
// one stimulus stream and are checked every cycle against a windowed history model.
module tb_max_pool2;

  typedef struct packed {
    logic            v;
    logic [3:0][7:0] d;  // d[0]=in00, d[1]=in01, d[2]=in10, d[3]=in11
  } ent_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            in_valid = 1'b0;
  logic [3:0][7:0] win = '0;

  int n_cmp  = 0;
  int n_fail = 0;
  ent_t hist[$];

  max_pool2_if #(.DATA_WIDTH(8)) if_u ();
  max_pool2_if #(.DATA_WIDTH(8)) if_s ();

  assign if_u.in_valid = in_valid;
  assign if_u.in00     = win[0];
  assign if_u.in01     = win[1];
  assign if_u.in10     = win[2];
  assign if_u.in11     = win[3];
  assign if_s.in_valid = in_valid;
  assign if_s.in00     = win[0];
  assign if_s.in01     = win[1];
  assign if_s.in10     = win[2];
  assign if_s.in11     = win[3];

  max_pool2 #(.DATA_WIDTH(8), .SIGNED(1'b0)) u_dut_u (.clk(clk), .rst_n(rst_n), .bus(if_u));
  max_pool2 #(.DATA_WIDTH(8), .SIGNED(1'b1)) u_dut_s (.clk(clk), .rst_n(rst_n), .bus(if_s));

  always #5 clk = ~clk;

  function automatic logic [3:0][7:0] mkw(input logic [7:0] a00, input logic [7:0] a01,
                                         input logic [7:0] a10, input logic [7:0] a11);
    return {a11, a10, a01, a00};
  endfunction

  function automatic int val(input logic [7:0] x, input bit sgn);
    if (sgn && x[7]) return int'(x) - 256;
    return int'(x);
  endfunction

  // Max over the four positions scanned in index order; ties keep the earlier position.
  function automatic void ref_pool(input logic [3:0][7:0] w, input bit sgn,
                                   output logic [7:0] mx, output logic [1:0] ix);
    int best;
    best = val(w[0], sgn);
    ix   = 2'd0;
    for (int i = 1; i < 4; i++) begin
      if (val(w[i], sgn) > best) begin
        best = val(w[i], sgn);
        ix   = 2'(i);
      end
    end
    mx = w[ix];
  endfunction

  // Output after the n-th post-reset edge reflects the window seen two edges earlier;
  // data holds the newest valid window at or before that point.
  function automatic void expect_now(input bit sgn, output bit ev, output logic [7:0] eo,
                                     output logic [1:0] ei);
    int n;
    n  = hist.size();
    ev = 1'b0;
    eo = '0;
    ei = '0;
    if (n >= 2) begin
      ev = hist[n-2].v;
      for (int k = n - 2; k >= 0; k--) begin
        if (hist[k].v) begin
          ref_pool(hist[k].d, sgn, eo, ei);
          break;
        end
      end
    end
  endfunction

  task automatic cmp(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic check_model(input string nm, input logic [3:0][7:0] w, input bit sgn,
                             input logic [7:0] em, input logic [1:0] ei);
    logic [7:0] m;
    logic [1:0] i;
    ref_pool(w, sgn, m, i);
    cmp({nm, "_max"}, m, em);
    cmp({nm, "_idx"}, i, ei);
  endtask

  task automatic drive(input bit v, input logic [3:0][7:0] w);
    @(negedge clk);
    in_valid = v;
    win      = w;
  endtask

  task automatic drive_rand(input bit v);
    drive(v, {8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)});
  endtask

  // Per-cycle compare process.
  initial begin
    bit         ev;
    logic [7:0] eo;
    logic [1:0] ei;
    forever begin
      @(posedge clk);
      if (!rst_n) hist.delete();
      else hist.push_back('{v: in_valid, d: win});
      #2;
      expect_now(1'b0, ev, eo, ei);
      cmp("u_out_valid", if_u.out_valid, ev);
      cmp("u_out", if_u.out, eo);
      cmp("u_out_idx", if_u.out_idx, ei);
      expect_now(1'b1, ev, eo, ei);
      cmp("s_out_valid", if_s.out_valid, ev);
      cmp("s_out", if_s.out, eo);
      cmp("s_out_idx", if_s.out_idx, ei);
    end
  end

  initial begin
    // Pin the model with hand-computed results.
    check_model("m_3_7", mkw(3, 7, 2, 1), 1'b0, 8'd7, 2'b01);
    check_model("m_10_9", mkw(10, 9, 8, 1), 1'b0, 8'd10, 2'b00);
    check_model("m_zero", mkw(0, 0, 0, 0), 1'b0, 8'd0, 2'b00);
    check_model("m_255", mkw(255, 23, 44, 12), 1'b0, 8'd255, 2'b00);
    check_model("m_8_11", mkw(8, 9, 10, 11), 1'b0, 8'd11, 2'b11);
    check_model("m_tie9", mkw(5, 9, 9, 9), 1'b0, 8'd9, 2'b01);
    check_model("m_tie6", mkw(4, 4, 6, 6), 1'b0, 8'd6, 2'b10);
    check_model("m_sgn", mkw(8'hFF, 8'h80, 8'h00, 8'hFE), 1'b1, 8'h00, 2'b10);
    check_model("m_uns", mkw(8'hFF, 8'h80, 8'h00, 8'hFE), 1'b0, 8'hFF, 2'b00);

    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, '0);
    drive(1'b0, '0);

    // Directed back-to-back windows.
    drive(1'b1, mkw(3, 7, 2, 1));
    drive(1'b1, mkw(10, 9, 8, 1));
    drive(1'b1, mkw(0, 0, 0, 0));
    drive(1'b1, mkw(255, 23, 44, 12));
    drive(1'b1, mkw(8, 9, 10, 11));
    drive(1'b1, mkw(5, 9, 9, 9));
    drive(1'b1, mkw(4, 4, 6, 6));
    drive(1'b1, mkw(8'hFF, 8'h80, 8'h00, 8'hFE));
    repeat (3) drive_rand(1'b0);

    // Bubbles with garbage on idle cycles.
    for (int i = 0; i < 12; i++) drive_rand(i % 2 == 0);

    // Reset mid-stream: outputs must clear without waiting for an edge.
    repeat (3) drive_rand(1'b1);
    #2 rst_n = 1'b0;
    #1;
    cmp("rst_async_u_out", if_u.out, 0);
    cmp("rst_async_u_idx", if_u.out_idx, 0);
    cmp("rst_async_u_valid", if_u.out_valid, 0);
    cmp("rst_async_s_out", if_s.out, 0);
    cmp("rst_async_s_valid", if_s.out_valid, 0);
    drive_rand(1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;
    repeat (3) drive_rand(1'b0);

    // Random traffic.
    for (int i = 0; i < 1000; i++) drive_rand($urandom_range(0, 3) != 0);
    repeat (4) drive_rand(1'b0);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
